alu_issue_unit: RTL and testbench

- Initiator side of the 3-bit ALU-operation interface. Accepts one instruction plus register operands on a valid/ready request channel.
- Decodes the instruction to an ALU operation code and drives registered operands and operation code to the combinational ALU.
- Captures result, zero and overflow after a configurable settle time, and returns them on a valid/ready response channel.
- Sits between the issue/decode stage and the ALU in the multi-cycle CPU datapath.

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_op_decode.sv | 79 +++++++
 rtl/alu_issue_unit.sv | 163 ++++++++++++++++
 tb/tb_alu_issue_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue path.
// Op codes, MIPS opcode/funct values and FSM states.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS instruction to ALU op/operand decoder.
// Shared with the single-cycle datapath.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [2:0]  op_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic        trapping_o,
    output logic        is_beq_o,
    output logic        is_bne_o,
    output logic        illegal_o
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] shamt_b;
    logic        unused_fields;

    assign opcode        = instr_i[31:26];
    assign funct         = instr_i[5:0];
    assign imm_s         = {{16{instr_i[15]}}, instr_i[15:0]};
    assign imm_z         = {16'b0, instr_i[15:0]};
    assign shamt_b       = {21'b0, instr_i[10:6], 6'b0};
    assign unused_fields = ^instr_i[25:16];

    // Map opcode/funct to op code, operands and trap/branch flags
    always_comb begin
        op_o       = OP_AND;
        a_o        = rs_i;
        b_o        = rt_i;
        trapping_o = 1'b0;
        is_beq_o   = 1'b0;
        is_bne_o   = 1'b0;
        illegal_o  = 1'b0;
        unique case (opcode)
            OPC_RTYPE: begin
                unique case (funct)
                    FN_ADD:  begin op_o = OP_ADD; trapping_o = 1'b1; end
                    FN_ADDU: op_o = OP_ADD;
                    FN_SUB:  begin op_o = OP_SUB; trapping_o = 1'b1; end
                    FN_SUBU: op_o = OP_SUB;
                    FN_AND:  op_o = OP_AND;
                    FN_OR:   op_o = OP_OR;
                    FN_XOR:  op_o = OP_XOR;
                    FN_NOR:  op_o = OP_NOR;
                    FN_SLT:  op_o = OP_SLT;
                    FN_SRL: begin
                        op_o = OP_SRL;
                        a_o  = rt_i;
                        b_o  = shamt_b;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_ADDI: begin
                op_o       = OP_ADD;
                b_o        = imm_s;
                trapping_o = 1'b1;
            end
            OPC_ADDIU: begin op_o = OP_ADD; b_o = imm_s; end
            OPC_SLTI:  begin op_o = OP_SLT; b_o = imm_s; end
            OPC_ANDI:  begin op_o = OP_AND; b_o = imm_z; end
            OPC_ORI:   begin op_o = OP_OR;  b_o = imm_z; end
            OPC_XORI:  begin op_o = OP_XOR; b_o = imm_z; end
            OPC_LW:    begin op_o = OP_ADD; b_o = imm_s; end
            OPC_SW:    begin op_o = OP_ADD; b_o = imm_s; end
            OPC_BEQ:   begin op_o = OP_SUB; is_beq_o = 1'b1; end
            OPC_BNE:   begin op_o = OP_SUB; is_bne_o = 1'b1; end
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues decoded instructions to the combinational ALU and
// returns the captured result on a valid/ready response channel.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_instr,
    input  logic [WIDTH-1:0] req_rs,
    input  logic [WIDTH-1:0] req_rt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_res,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_branch,
    output logic             rsp_illegal,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             busy
);

    state_e state_q, state_d;

    logic [2:0]       dec_op;
    logic [WIDTH-1:0] dec_a, dec_b;
    logic             dec_trap, dec_beq, dec_bne, dec_ill;

    logic [WIDTH-1:0] alu_a_q, alu_b_q;
    logic [2:0]       alu_op_q;
    logic             trap_q, beq_q, bne_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q, ovf_q, branch_q, ill_q;

    logic accept;
    logic capture;

    alu_op_decode u_dec (
        .instr_i    (req_instr),
        .rs_i       (req_rs),
        .rt_i       (req_rt),
        .op_o       (dec_op),
        .a_o        (dec_a),
        .b_o        (dec_b),
        .trapping_o (dec_trap),
        .is_beq_o   (dec_beq),
        .is_bne_o   (dec_bne),
        .illegal_o  (dec_ill)
    );

    assign accept  = req_valid & req_ready;
    assign capture = (state_q == ST_EXEC) && (cnt_q == 8'd0);

    // State register; reset drops any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state: illegal requests bypass EXEC
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) state_d = dec_ill ? ST_RESP : ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q == 8'd0) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (req_valid) state_d = dec_ill ? ST_RESP : ST_EXEC;
                    else           state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; a new request is taken as the response retires
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_EXEC: req_ready = 1'b0;
            ST_RESP: begin
                req_ready = rsp_ready;
                rsp_valid = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    // ALU drive registers, latency counter and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= OP_AND;
            trap_q   <= 1'b0;
            beq_q    <= 1'b0;
            bne_q    <= 1'b0;
            cnt_q    <= 8'd0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            branch_q <= 1'b0;
            ill_q    <= 1'b0;
        end else if (accept) begin
            if (dec_ill) begin
                res_q    <= '0;
                zero_q   <= 1'b0;
                ovf_q    <= 1'b0;
                branch_q <= 1'b0;
                ill_q    <= 1'b1;
            end else begin
                alu_a_q  <= dec_a;
                alu_b_q  <= dec_b;
                alu_op_q <= dec_op;
                trap_q   <= dec_trap;
                beq_q    <= dec_beq;
                bne_q    <= dec_bne;
                cnt_q    <= 8'(ALU_LAT);
            end
        end else if (capture) begin
            res_q    <= alu_res;
            zero_q   <= alu_zero;
            ovf_q    <= alu_overflow & trap_q;
            branch_q <= (beq_q & alu_zero) | (bne_q & ~alu_zero);
            ill_q    <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            cnt_q <= cnt_q - 8'd1;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rsp_res     = res_q;
    assign rsp_zero    = zero_q;
    assign rsp_ovf     = ovf_q;
    assign rsp_branch  = branch_q;
    assign rsp_illegal = ill_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with ALU_LAT=0 and ALU_LAT=3.
// A behavioural ALU closes the loop on each instance.
module tb_alu_issue_unit;

    logic        clk;
    logic        rst_n, rst3;
    logic        req_valid, v3;
    logic        rsp_ready, rr3;
    logic [31:0] req_instr, req_rs, req_rt;

    logic        req_ready, rsp_valid, rsp_zero, rsp_ovf;
    logic        rsp_branch, rsp_illegal, busy;
    logic [31:0] rsp_res, alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_overflow;

    logic        req_ready3, rsp_valid3, rsp_zero3, rsp_ovf3;
    logic        rsp_branch3, rsp_illegal3, busy3;
    logic [31:0] rsp_res3, alu_a3, alu_b3, alu_res3;
    logic [2:0]  alu_op3;
    logic        alu_zero3, alu_overflow3;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] alu_f(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] r;
        logic        v;
        v = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                r = a + b;
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b011: r = a ^ b;
            3'b100: r = ~(a | b);
            3'b101: r = a >> b[10:6];
            3'b110: begin
                r = a - b;
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = {31'b0, $signed(a) < $signed(b)};
        endcase
        return {v, (r == 32'b0), r};
    endfunction

    always_comb {alu_overflow, alu_zero, alu_res} = alu_f(alu_op, alu_a, alu_b);
    always_comb {alu_overflow3, alu_zero3, alu_res3} = alu_f(alu_op3, alu_a3, alu_b3);

    alu_issue_unit #(.WIDTH(32), .ALU_LAT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instr(req_instr), .req_rs(req_rs), .req_rt(req_rt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf),
        .rsp_branch(rsp_branch), .rsp_illegal(rsp_illegal),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_res(alu_res), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .busy(busy)
    );

    alu_issue_unit #(.WIDTH(32), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3),
        .req_valid(v3), .req_ready(req_ready3),
        .req_instr(req_instr), .req_rs(req_rs), .req_rt(req_rt),
        .rsp_valid(rsp_valid3), .rsp_ready(rr3),
        .rsp_res(rsp_res3), .rsp_zero(rsp_zero3), .rsp_ovf(rsp_ovf3),
        .rsp_branch(rsp_branch3), .rsp_illegal(rsp_illegal3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
        .alu_res(alu_res3), .alu_zero(alu_zero3),
        .alu_overflow(alu_overflow3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue a legal request to the LAT=0 unit and stop in RESP
    task automatic run_legal(input logic [31:0] ins, input logic [31:0] rs,
                             input logic [31:0] rt);
        req_instr = ins;
        req_rs    = rs;
        req_rt    = rt;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("exec_no_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0; rst3 = 1'b0;
        req_valid = 1'b0; v3 = 1'b0;
        rsp_ready = 1'b1; rr3 = 1'b1;
        req_instr = '0; req_rs = '0; req_rt = '0;
        #3;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; rst3 = 1'b1;
        tick();

        // add with signed overflow
        req_instr = 32'h0000_0020; req_rs = 32'h7FFF_FFFF; req_rt = 32'd1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("add_op", {29'b0, alu_op}, 32'd2);
        chk("add_busy", {31'b0, busy}, 32'd1);
        chk("add_exec_ready", {31'b0, req_ready}, 32'd0);
        chk("add_exec_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
        chk("add_valid", {31'b0, rsp_valid}, 32'd1);
        chk("add_res", rsp_res, 32'h8000_0000);
        chk("add_ovf", {31'b0, rsp_ovf}, 32'd1);
        tick();
        chk("add_idle", {31'b0, rsp_valid}, 32'd0);

        run_legal(32'h0000_0021, 32'h7FFF_FFFF, 32'd1);
        chk("addu_res", rsp_res, 32'h8000_0000);
        chk("addu_ovf", {31'b0, rsp_ovf}, 32'd0);
        tick();

        run_legal(32'h1000_0000, 32'd5, 32'd5);
        chk("beq_op", {29'b0, alu_op}, 32'd6);
        chk("beq_zero", {31'b0, rsp_zero}, 32'd1);
        chk("beq_branch", {31'b0, rsp_branch}, 32'd1);
        tick();

        run_legal(32'h1400_0000, 32'd5, 32'd5);
        chk("bne_zero", {31'b0, rsp_zero}, 32'd1);
        chk("bne_branch", {31'b0, rsp_branch}, 32'd0);
        tick();

        run_legal(32'h0000_0102, 32'h0000_0055, 32'h0000_00F0);
        chk("srl_a", alu_a, 32'h0000_00F0);
        chk("srl_b", alu_b, 32'h0000_0100);
        chk("srl_res", rsp_res, 32'h0000_000F);
        tick();

        run_legal(32'h3000_FFFF, 32'h1234_5678, 32'd0);
        chk("andi_b", alu_b, 32'h0000_FFFF);
        chk("andi_res", rsp_res, 32'h0000_5678);
        tick();

        // illegal opcode 111111
        req_instr = 32'hFC00_0000; req_rs = 32'hDEAD_BEEF; req_rt = 32'h1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("ill_valid", {31'b0, rsp_valid}, 32'd1);
        chk("ill_flag", {31'b0, rsp_illegal}, 32'd1);
        chk("ill_res", rsp_res, 32'd0);
        chk("ill_op_kept", {29'b0, alu_op}, 32'd0);
        chk("ill_a_kept", alu_a, 32'h1234_5678);
        chk("ill_b_kept", alu_b, 32'h0000_FFFF);
        tick();

        // back-pressure then overlapped accept
        rsp_ready = 1'b0;
        run_legal(32'h3400_00F0, 32'h0000_000F, 32'd0);
        req_instr = 32'h0000_0022; req_rs = 32'd10; req_rt = 32'd3;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_res", rsp_res, 32'h0000_00FF);
            chk("bp_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_ready_on", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        chk("ovl_valid_drop", {31'b0, rsp_valid}, 32'd0);
        chk("ovl_op", {29'b0, alu_op}, 32'd6);
        chk("ovl_a", alu_a, 32'd10);
        tick();
        chk("sub_valid", {31'b0, rsp_valid}, 32'd1);
        chk("sub_res", rsp_res, 32'd7);
        chk("sub_ovf", {31'b0, rsp_ovf}, 32'd0);
        tick();

        // ALU_LAT=3 latency with addi
        req_instr = 32'h2000_FFFF; req_rs = 32'd5; req_rt = 32'd0;
        v3 = 1'b1;
        tick();
        v3 = 1'b0;
        lat = 1;
        while (!rsp_valid3 && lat < 20) begin
            tick();
            lat++;
        end
        chk("lat3_cycles", lat, 32'd5);
        chk("lat3_res", rsp_res3, 32'd4);
        tick();

        // reset in the middle of EXEC
        req_instr = 32'h0000_0021; req_rs = 32'd1; req_rt = 32'd2;
        v3 = 1'b1;
        tick();
        v3 = 1'b0;
        tick();
        chk("mid_busy", {31'b0, busy3}, 32'd1);
        rst3 = 1'b0;
        #1;
        chk("mid_ready", {31'b0, req_ready3}, 32'd1);
        chk("mid_busy0", {31'b0, busy3}, 32'd0);
        chk("mid_valid0", {31'b0, rsp_valid3}, 32'd0);
        chk("mid_a0", alu_a3, 32'd0);
        chk("mid_res0", rsp_res3, 32'd0);
        tick();
        rst3 = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid3) seen++;
        end
        chk("mid_no_stale", seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
